// File: rtl/led_matrix_scan_if.sv
// led_matrix_scan_if: scan strobe, frame-buffer read handshake and matrix drive signals.
interface led_matrix_scan_if #(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1
);
    logic            scan_tick;
    logic            enable;
    logic            rd_req;
    logic [RW-1:0]   rd_row;
    logic [COLS-1:0] rd_data;
    logic            rd_valid;
    logic [ROWS-1:0] row_sel;
    logic [COLS-1:0] col_data;
    logic            frame_done;
    logic            overrun;

    modport master (
        output scan_tick, enable, rd_data, rd_valid,
        input  rd_req, rd_row, row_sel, col_data, frame_done, overrun
    );

    modport slave (
        input  scan_tick, enable, rd_data, rd_valid,
        output rd_req, rd_row, row_sel, col_data, frame_done, overrun
    );
endinterface

// File: rtl/led_matrix_scan.sv
// led_matrix_scan: row-at-a-time 8x8 matrix scanner with blanking and frame-buffer fetch.
module led_matrix_scan #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    led_matrix_scan_if.slave     bus
);
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int CW = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, BLANK, FETCH, SHOW} state_t;

    state_t          state, state_nx;
    logic [RW-1:0]   row_idx, row_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [ROWS-1:0] row_sel_nx;
    logic [COLS-1:0] col_nx;
    logic            done_nx, ovr_nx, tick;

    assign tick = bus.enable && bus.scan_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            row_idx        <= '0;
            cnt            <= '0;
            bus.rd_req     <= 1'b0;
            bus.rd_row     <= '0;
            bus.row_sel    <= '0;
            bus.col_data   <= '0;
            bus.frame_done <= 1'b0;
            bus.overrun    <= 1'b0;
        end else begin
            state          <= state_nx;
            row_idx        <= row_nx;
            cnt            <= cnt_nx;
            bus.rd_req     <= state_nx == FETCH;
            bus.rd_row     <= row_nx;
            bus.row_sel    <= row_sel_nx;
            bus.col_data   <= col_nx;
            bus.frame_done <= done_nx;
            bus.overrun    <= ovr_nx;
        end
    end

    // disable wins over every other event and parks the scanner at row 0
    always_comb begin
        state_nx = state;
        row_nx   = row_idx;
        cnt_nx   = cnt;
        if (!bus.enable) begin
            state_nx = IDLE;
            row_nx   = '0;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: if (tick) begin
                    state_nx = BLANK;
                    cnt_nx   = CW'(BLANK_CYCLES - 1);
                end
                BLANK: if (cnt == '0) state_nx = FETCH;
                       else cnt_nx = cnt - 1'b1;
                FETCH: if (bus.rd_valid) state_nx = SHOW;
                SHOW: if (tick) begin
                    state_nx = BLANK;
                    cnt_nx   = CW'(BLANK_CYCLES - 1);
                    row_nx   = row_idx == RW'(ROWS - 1) ? '0 : row_idx + 1'b1;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        row_sel_nx = state_nx == SHOW ? ROWS'(1) << row_nx : '0;
        col_nx     = state_nx != SHOW ? '0 : state == FETCH ? bus.rd_data : bus.col_data;
        done_nx    = tick && state == SHOW && row_idx == RW'(ROWS - 1);
        ovr_nx     = bus.overrun || (tick && (state == BLANK || state == FETCH));
    end
endmodule

// File: tb/tb_led_matrix_scan.sv
// tb_led_matrix_scan: random stimulus against a timeline model of the matrix scanner.
module tb_led_matrix_scan;
    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int BC   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    led_matrix_scan_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    led_matrix_scan #(.ROWS(ROWS), .COLS(COLS), .BLANK_CYCLES(BC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // model: what the display is doing, expressed as remaining blank time and flags
    int   m_row, m_blank_left;
    bit   m_waiting, m_lit, m_ovr, m_done;
    logic [COLS-1:0] m_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_row = 0; m_blank_left = 0; m_waiting = 0; m_lit = 0; m_ovr = 0; m_done = 0; m_data = '0;
    endtask

    task automatic model_step(input bit tk, input bit en, input bit vld, input logic [COLS-1:0] dat);
        m_done = 0;
        if (!en) begin
            m_row = 0; m_blank_left = 0; m_waiting = 0; m_lit = 0;
        end else if (m_blank_left > 0) begin
            if (tk) m_ovr = 1;
            m_blank_left--;
            if (m_blank_left == 0) m_waiting = 1;
        end else if (m_waiting) begin
            if (tk) m_ovr = 1;
            if (vld) begin m_data = dat; m_waiting = 0; m_lit = 1; end
        end else if (m_lit) begin
            if (tk) begin
                m_row = (m_row + 1) % ROWS;
                m_done = (m_row == 0);
                m_lit = 0;
                m_blank_left = BC;
            end
        end else if (tk) begin
            m_blank_left = BC;
        end
    endtask

    task automatic check_outputs();
        check("row_sel", 32'(bus.row_sel), m_lit ? 32'(1) << m_row : 32'd0);
        check("col_data", 32'(bus.col_data), m_lit ? 32'(m_data) : 32'd0);
        check("rd_req", 32'(bus.rd_req), 32'(m_waiting));
        if (m_waiting) check("rd_row", 32'(bus.rd_row), 32'(m_row));
        check("frame_done", 32'(bus.frame_done), 32'(m_done));
        check("overrun", 32'(bus.overrun), 32'(m_ovr));
    endtask

    task automatic run(input int cycles, input int tick_pct, input int vld_pct, input int dis_per_mil);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            bus.scan_tick = $urandom_range(0, 99) < tick_pct;
            bus.enable    = $urandom_range(0, 999) >= dis_per_mil;
            bus.rd_valid  = $urandom_range(0, 99) < vld_pct;
            bus.rd_data   = COLS'($urandom);
            @(posedge clk);
            model_step(bus.scan_tick, bus.enable, bus.rd_valid, bus.rd_data);
            #1 check_outputs();
        end
    endtask

    initial begin
        bus.scan_tick = 0; bus.enable = 0; bus.rd_valid = 0; bus.rd_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_outputs();
        @(negedge clk) rst_n = 1'b1;
        // sparse ticks, prompt reads: full frames with wrap
        run(3000, 3, 60, 0);
        // slow reads and dense ticks: long fetches, overruns
        run(1500, 10, 15, 0);
        // occasional disables mid-scan
        run(3000, 4, 40, 5);
        begin
            int n = 0;
            bus.enable = 1;
            while (!m_lit && n < 500) begin
                run(1, 5, 50, 0);
                n++;
            end
            check("reach_show", 32'(m_lit), 32'd1);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("rst_async_row_sel", 32'(bus.row_sel), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        run(2000, 3, 50, 2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
